// File: rtl/my_cpu_if.sv
// my_cpu_if: instruction feed and writeback debug bus of the core.
// master = stimulus side, slave = the core.
interface my_cpu_if;
  logic [31:0] inst;
  logic        dbg_wb_en;
  logic [4:0]  dbg_wb_rd;
  logic [31:0] dbg_wb_data;

  modport master (
    output inst,
    input  dbg_wb_en,
    input  dbg_wb_rd,
    input  dbg_wb_data
  );

  modport slave (
    input  inst,
    output dbg_wb_en,
    output dbg_wb_rd,
    output dbg_wb_data
  );
endinterface

// File: rtl/my_cpu.sv
// my_cpu: five-stage RV32I core (IF ID EX MEM WB), ALU subset only.
// Macro FORWARD_EN adds EX-stage forwarding from EX/MEM and MEM/WB.
module my_cpu (
  input  logic    cpu_clk,
  input  logic    cpu_rst,
  my_cpu_if.slave bus
);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [4:0]  rd;
`ifdef FORWARD_EN
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_rs2;
`endif
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] res;
  } res_t;

  if_id_t      ifid_q, ifid_d;
  id_ex_t      idex_q, idex_d;
  res_t        exmem_q, exmem_d;
  res_t        memwb_q, memwb_d;
  logic [31:0] rf_q [32];

  logic [31:0] inst;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic        is_op, is_imm, is_lui;

  assign inst   = ifid_q.inst;
  assign opc    = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];
  assign is_op  = (opc == 7'b0110011);
  assign is_imm = (opc == 7'b0010011);
  assign is_lui = (opc == 7'b0110111);

  logic        legal, alt, use_rs2;
  logic [4:0]  src1;
  logic [31:0] imm, rval1, rval2;
  alu_op_e     op;

  logic        wb_hit1, wb_hit2, wb_wr;
  assign wb_wr   = memwb_q.valid & memwb_q.wen;
  assign wb_hit1 = wb_wr & (memwb_q.rd == src1);
  assign wb_hit2 = wb_wr & (memwb_q.rd == rs2);

  // IF: capture the incoming instruction every cycle
  always_comb begin
    ifid_d       = '0;
    ifid_d.valid = 1'b1;
    ifid_d.inst  = bus.inst;
  end

  // ID: decode, legality, register read with write-first bypass
  always_comb begin
    legal   = 1'b0;
    alt     = 1'b0;
    use_rs2 = 1'b0;
    src1    = rs1;
    imm     = {{20{inst[31]}}, inst[31:20]};
    op      = ALU_ADD;
    unique case (1'b1)
      is_op: begin
        legal   = (f7 == 7'h00) |
                  ((f7 == 7'h20) &
                   ((f3 == 3'b000) | (f3 == 3'b101)));
        alt     = f7[5];
        use_rs2 = 1'b1;
      end
      is_imm: begin
        if (f3 == 3'b001)
          legal = (f7 == 7'h00);
        else if (f3 == 3'b101)
          legal = (f7 == 7'h00) | (f7 == 7'h20);
        else
          legal = 1'b1;
        alt = (f3 == 3'b101) & f7[5];
      end
      is_lui: begin
        legal = 1'b1;
        src1  = 5'd0;
        imm   = {inst[31:12], 12'h000};
      end
      default: ;
    endcase
    unique case (f3)
      3'b000: op = alt ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      3'b111: op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    if (is_lui)
      op = ALU_ADD;
    rval1 = wb_hit1 ? memwb_q.res : rf_q[src1];
    rval2 = wb_hit2 ? memwb_q.res : rf_q[rs2];
    idex_d         = '0;
    idex_d.valid   = ifid_q.valid;
    idex_d.wen     = ifid_q.valid & legal & (rd != 5'd0);
    idex_d.rd      = rd;
`ifdef FORWARD_EN
    idex_d.rs1     = src1;
    idex_d.rs2     = rs2;
    idex_d.use_rs2 = use_rs2;
`endif
    idex_d.a       = rval1;
    idex_d.b       = use_rs2 ? rval2 : imm;
    idex_d.op      = op;
  end

  logic [31:0] opa, opb, res;

`ifdef FORWARD_EN
  logic em_a, em_b, mw_a, mw_b;
  assign em_a = exmem_q.valid & exmem_q.wen &
                (exmem_q.rd == idex_q.rs1) & (idex_q.rs1 != 5'd0);
  assign mw_a = memwb_q.valid & memwb_q.wen &
                (memwb_q.rd == idex_q.rs1) & (idex_q.rs1 != 5'd0);
  assign em_b = idex_q.use_rs2 & exmem_q.valid & exmem_q.wen &
                (exmem_q.rd == idex_q.rs2) & (idex_q.rs2 != 5'd0);
  assign mw_b = idex_q.use_rs2 & memwb_q.valid & memwb_q.wen &
                (memwb_q.rd == idex_q.rs2) & (idex_q.rs2 != 5'd0);

  // EX operand select: youngest matching producer wins
  always_comb begin
    opa = idex_q.a;
    opb = idex_q.b;
    if (em_a)
      opa = exmem_q.res;
    else if (mw_a)
      opa = memwb_q.res;
    if (em_b)
      opb = exmem_q.res;
    else if (mw_b)
      opb = memwb_q.res;
  end
`else
  // EX operands come straight from ID
  always_comb begin
    opa = idex_q.a;
    opb = idex_q.b;
  end
`endif

  // EX: ALU
  always_comb begin
    res = '0;
    unique case (idex_q.op)
      ALU_ADD:  res = opa + opb;
      ALU_SUB:  res = opa - opb;
      ALU_SLL:  res = opa << opb[4:0];
      ALU_SLT:  res = {31'd0, $signed(opa) < $signed(opb)};
      ALU_SLTU: res = {31'd0, opa < opb};
      ALU_XOR:  res = opa ^ opb;
      ALU_SRL:  res = opa >> opb[4:0];
      ALU_SRA:  res = $unsigned($signed(opa) >>> opb[4:0]);
      ALU_OR:   res = opa | opb;
      ALU_AND:  res = opa & opb;
      default:  res = '0;
    endcase
    exmem_d       = '0;
    exmem_d.valid = idex_q.valid;
    exmem_d.wen   = idex_q.wen;
    exmem_d.rd    = idex_q.rd;
    exmem_d.res   = res;
  end

  // MEM: plain pass-through
  always_comb begin
    memwb_d = exmem_q;
  end

  // Pipeline registers, reset to bubbles
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ifid_q  <= '0;
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      ifid_q  <= ifid_d;
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  // Register file write from WB; x0 never written
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else if (wb_wr) begin
      rf_q[memwb_q.rd] <= memwb_q.res;
    end
  end

  assign bus.dbg_wb_en   = wb_wr;
  assign bus.dbg_wb_rd   = wb_wr ? memwb_q.rd : 5'd0;
  assign bus.dbg_wb_data = wb_wr ? memwb_q.res : 32'd0;

endmodule

// File: tb/tb_my_cpu.sv
// tb_my_cpu: table-driven instruction stream, scoreboard on the WB port.
// Expected data is given for both the forwarding and non-forwarding build.
module tb_my_cpu;

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  my_cpu_if bus();

  my_cpu dut (
    .cpu_clk (cpu_clk),
    .cpu_rst (cpu_rst),
    .bus     (bus)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    bit          en;
    logic [4:0]  rd;
    logic [31:0] df;
    logic [31:0] dn;
  } vec_t;

  typedef struct {
    int          due;
    logic [37:0] exp;
    string       nm;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [31:0] op_i(input logic [2:0] f3,
    input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] op_r(input logic [6:0] f7,
    input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] lui(input logic [4:0] rd,
    input logic [19:0] imm);
    return {imm, rd, 7'h37};
  endfunction

  task automatic v(input logic [31:0] inst, input bit en,
    input logic [4:0] rd, input logic [31:0] df, input logic [31:0] dn);
    vec_t e;
    e.inst = inst; e.en = en; e.rd = rd; e.df = df; e.dn = dn;
    tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [37:0] act,
    input logic [37:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got en=%0b rd=%0d data=%h, expected en=%0b rd=%0d data=%h",
        nm, act[37], act[36:32], act[31:0], exp[37], exp[36:32], exp[31:0]);
    end
  endtask

  function automatic logic [37:0] wb_now();
    return {bus.dbg_wb_en, bus.dbg_wb_rd, bus.dbg_wb_data};
  endfunction

  // called at a negedge: compare the entry whose result is due now
  task automatic check_due();
    sb_t e;
    while (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: result slot missed (due %0d, now %0d)",
        e.nm, e.due, cyc);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk(e.nm, wb_now(), e.exp);
    end
  endtask

  task automatic step(input logic [31:0] inst, input bit en,
    input logic [4:0] rd, input logic [31:0] d, input string nm);
    sb_t e;
    @(negedge cpu_clk);
    check_due();
    bus.inst = inst;
    e.due = cyc + 4;
    e.exp = en ? {1'b1, rd, d} : 38'd0;
    e.nm  = nm;
    sb.push_back(e);
    @(posedge cpu_clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 12) begin
      @(negedge cpu_clk);
      bus.inst = 32'h0;
      check_due();
      n++;
    end
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d results never appeared", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.inst = 32'h0;

    v(op_i(3'b000, 5'd1, 5'd0, 12'd9), 1, 5'd1, 32'd9, 32'd9);
    v(32'h40628533, 1, 5'd10, 32'd0, 32'd0);
    v(32'h00308113, 1, 5'd2, 32'd12, 32'd3);
    repeat (3) v(NOP, 0, 5'd0, 32'd0, 32'd0);
    v(op_i(3'b000, 5'd1, 5'd0, 12'd5), 1, 5'd1, 32'd5, 32'd5);
    v(op_r(7'h00, 3'b000, 5'd3, 5'd1, 5'd1), 1, 5'd3, 32'd10, 32'd18);
    repeat (3) v(NOP, 0, 5'd0, 32'd0, 32'd0);
    v(op_i(3'b000, 5'd1, 5'd0, 12'd1), 1, 5'd1, 32'd1, 32'd1);
    v(op_i(3'b000, 5'd1, 5'd0, 12'd2), 1, 5'd1, 32'd2, 32'd2);
    v(op_r(7'h00, 3'b000, 5'd4, 5'd1, 5'd0), 1, 5'd4, 32'd2, 32'd5);
    repeat (3) v(NOP, 0, 5'd0, 32'd0, 32'd0);
    v(lui(5'd5, 20'h80000), 1, 5'd5, 32'h8000_0000, 32'h8000_0000);
    repeat (3) v(NOP, 0, 5'd0, 32'd0, 32'd0);
    v(op_i(3'b101, 5'd6, 5'd5, {7'h20, 5'd4}), 1, 5'd6,
      32'hF800_0000, 32'hF800_0000);
    v(op_i(3'b101, 5'd7, 5'd5, {7'h00, 5'd4}), 1, 5'd7,
      32'h0800_0000, 32'h0800_0000);
    v(op_i(3'b000, 5'd0, 5'd0, 12'd7), 0, 5'd0, 32'd0, 32'd0);
    v(op_r(7'h00, 3'b000, 5'd8, 5'd0, 5'd0), 1, 5'd8, 32'd0, 32'd0);
    v(op_r(7'h00, 3'b010, 5'd11, 5'd6, 5'd7), 1, 5'd11, 32'd1, 32'd1);
    v(op_r(7'h00, 3'b011, 5'd12, 5'd6, 5'd7), 1, 5'd12, 32'd0, 32'd0);
    v(op_r(7'h00, 3'b100, 5'd13, 5'd6, 5'd7), 1, 5'd13,
      32'hF000_0000, 32'hF000_0000);
    v(op_r(7'h00, 3'b110, 5'd14, 5'd6, 5'd7), 1, 5'd14,
      32'hF800_0000, 32'hF800_0000);
    v(op_r(7'h00, 3'b111, 5'd15, 5'd6, 5'd7), 1, 5'd15,
      32'h0800_0000, 32'h0800_0000);
    v(op_r(7'h00, 3'b001, 5'd16, 5'd7, 5'd1), 1, 5'd16,
      32'h2000_0000, 32'h2000_0000);
    v(op_r(7'h00, 3'b101, 5'd17, 5'd6, 5'd1), 1, 5'd17,
      32'h3E00_0000, 32'h3E00_0000);
    v(op_r(7'h20, 3'b101, 5'd18, 5'd6, 5'd1), 1, 5'd18,
      32'hFE00_0000, 32'hFE00_0000);
    v(op_i(3'b010, 5'd19, 5'd6, 12'hFFF), 1, 5'd19, 32'd1, 32'd1);
    v(op_i(3'b011, 5'd20, 5'd7, 12'hFFF), 1, 5'd20, 32'd1, 32'd1);
    v(op_i(3'b100, 5'd21, 5'd7, 12'hFFF), 1, 5'd21,
      32'hF7FF_FFFF, 32'hF7FF_FFFF);
    v(op_i(3'b110, 5'd22, 5'd1, 12'h7F0), 1, 5'd22, 32'h7F2, 32'h7F2);
    v(op_i(3'b111, 5'd23, 5'd21, 12'h0F0), 1, 5'd23, 32'hF0, 32'h0);
    v(op_i(3'b001, 5'd24, 5'd7, {7'h00, 5'd4}), 1, 5'd24,
      32'h8000_0000, 32'h8000_0000);
    v(op_r(7'h00, 3'b000, 5'd25, 5'd5, 5'd5), 1, 5'd25, 32'd0, 32'd0);
    v(op_r(7'h20, 3'b000, 5'd26, 5'd0, 5'd1), 1, 5'd26,
      32'hFFFF_FFFE, 32'hFFFF_FFFE);
    v(op_i(3'b000, 5'd27, 5'd0, 12'h800), 1, 5'd27,
      32'hFFFF_F800, 32'hFFFF_F800);
    v(op_r(7'h00, 3'b000, 5'd28, 5'd27, 5'd26), 1, 5'd28,
      32'hFFFF_F7FE, 32'h0);
    v(32'hFFFF_FFFF, 0, 5'd0, 32'd0, 32'd0);
    v(op_r(7'h20, 3'b001, 5'd29, 5'd1, 5'd1), 0, 5'd0, 32'd0, 32'd0);
    v(op_r(7'h00, 3'b000, 5'd29, 5'd29, 5'd1), 1, 5'd29, 32'd2, 32'd2);
    v(op_i(3'b101, 5'd30, 5'd5, {7'h20, 5'd31}), 1, 5'd30,
      32'hFFFF_FFFF, 32'hFFFF_FFFF);
    v(op_i(3'b000, 5'd31, 5'd0, 12'd77), 1, 5'd31, 32'd77, 32'd77);
    repeat (2) v(NOP, 0, 5'd0, 32'd0, 32'd0);
    v(op_r(7'h00, 3'b000, 5'd2, 5'd31, 5'd31), 1, 5'd2, 32'd154, 32'd154);

    // reset state
    cpu_rst = 1'b1;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    chk("reset_wb", wb_now(), 38'd0);
    cpu_rst = 1'b0;

    foreach (tbl[i])
      step(tbl[i].inst, tbl[i].en, tbl[i].rd,
           FWD ? tbl[i].df : tbl[i].dn, $sformatf("vec%0d", i));
    drain();

    // reset hits the edge where addi x9 would be written back
    step(op_i(3'b000, 5'd9, 5'd0, 12'd3), 1, 5'd9, 32'd3, "x9_wb");
    repeat (3) step(NOP, 0, 5'd0, 32'd0, "pre_rst_nop");
    @(negedge cpu_clk);
    check_due();
    cpu_rst  = 1'b1;
    bus.inst = op_i(3'b000, 5'd9, 5'd0, 12'd5);
    sb.delete();
    @(posedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rst  = 1'b0;
    bus.inst = NOP;
    chk("mid_rst_wb", wb_now(), 38'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      chk($sformatf("post_rst%0d", i), wb_now(), 38'd0);
    end
    repeat (3) step(NOP, 0, 5'd0, 32'd0, "post_rst_nop");
    step(op_r(7'h00, 3'b000, 5'd12, 5'd9, 5'd0), 1, 5'd12, 32'd0,
         "x9_after_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
